// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry,
// and the baud-rate select codes understood by baud_gen_rx.
package uart_pkg;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;

  localparam logic [1:0] BAUD_9600   = 2'b00;
  localparam logic [1:0] BAUD_19200  = 2'b01;
  localparam logic [1:0] BAUD_57600  = 2'b10;
  localparam logic [1:0] BAUD_115200 = 2'b11;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_t;

  // Total ones over data plus parity bit must match the selected sense.
  function automatic logic parity_mismatch(input logic data_xor,
                                           input logic sample,
                                           input logic odd);
    return (data_xor ^ sample) != odd;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable
// reset value so idle-high lines come out of reset inactive.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Oversampling UART receiver: start-bit qualification, LSB-first data,
// optional parity, stop/break handling and a single-entry output register.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 data_rd,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy,
  output logic [2:0]           state_dbg
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = RX_IDLE;
  localparam logic [2:0] S_START  = RX_START;
  localparam logic [2:0] S_DATA   = RX_DATA;
  localparam logic [2:0] S_PARITY = RX_PARITY;
  localparam logic [2:0] S_STOP   = RX_STOP;
  localparam logic [2:0] S_BREAK  = RX_BREAK;

  logic rxs;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rxs)
  );

  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic                 par_bad_q, par_bad_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 dv_q, dv_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 commit;

  // Frame FSM. Every sampling point is gated by baud_tick, so a stalled
  // tick stream freezes the receiver in place.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    par_bad_d = par_bad_q;
    commit    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d   = S_START;
          tick_d    = '0;
          bit_d     = '0;
          par_en_d  = parity_en;
          par_odd_d = parity_odd;
          par_bad_d = 1'b0;
        end
      end
      S_START: begin
        if (baud_tick) begin
          if (tick_q == TICK_MID) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rxs ? S_IDLE : S_DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          tick_d = tick_q + 1'b1;
          if (tick_q == TICK_LAST) begin
            shift_d = {rxs, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
              state_d = par_en_q ? S_PARITY : S_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          tick_d = tick_q + 1'b1;
          if (tick_q == TICK_LAST) begin
            par_bad_d = parity_mismatch(^shift_q, rxs, par_odd_q);
            state_d   = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          tick_d = tick_q + 1'b1;
          if (tick_q == TICK_LAST) begin
            commit  = 1'b1;
            state_d = rxs ? S_IDLE : S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output handshake: data_valid is a level that stays high until a
  // data_rd pulse is seen while it is high; a new frame landing on an
  // unread byte overwrites it and raises overrun unless that same cycle
  // also carries data_rd.
  always_comb begin
    dout_d = dout_q;
    dv_d   = dv_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    ovr_d  = ovr_q;
    if (commit) begin
      dout_d = shift_q;
      perr_d = par_en_q & par_bad_q;
      ferr_d = ~rxs;
      dv_d   = 1'b1;
      if (dv_q && !data_rd) ovr_d = 1'b1;
    end else if (data_rd && dv_q) begin
      dv_d  = 1'b0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_bad_q <= 1'b0;
      dout_q    <= '0;
      dv_q      <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      par_bad_q <= par_bad_d;
      dout_q    <= dout_d;
      dv_q      <= dv_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != S_IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: baud_tick every 4 clk, 16x oversampling,
// frames aligned to the tick phase so commit timing is exact.
module tb_uart_rx_ctrl;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_BREAK = 3'd5;
  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx_in = 1'b1;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       data_rd = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rise_k;
  logic [7:0] snap_dout;
  logic       snap_dv, snap_perr, snap_ferr, snap_ovr, snap_busy;

  uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .rx_in      (rx_in),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .data_rd    (data_rd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  initial forever #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    cyc++;
    baud_tick = (cyc % 4 == 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic pulse_rd();
    data_rd = 1'b1;
    step();
    data_rd = 1'b0;
    step();
  endtask

  // Drives one frame starting on a baud_tick cycle (k=0). rd_at/rst_at
  // give the k index for a one-cycle data_rd / two-cycle rst (-1 = none).
  task automatic send_frame(input logic [7:0] d, input logic use_par,
                            input logic par_bit, input logic stop_bit,
                            input int rd_at, input int rst_at, input logic flip_cfg);
    int   nper;
    int   p;
    logic prev_dv;
    nper   = use_par ? 11 : 10;
    rise_k = -1;
    while (cyc % 4 != 3) step();
    prev_dv = data_valid;
    for (int k = 0; k < nper * BIT_CLKS; k++) begin
      step();
      p = k / BIT_CLKS;
      if (p == 0) rx_in = 1'b0;
      else if (p <= 8) rx_in = d[p-1];
      else if (use_par && p == 9) rx_in = par_bit;
      else rx_in = stop_bit;
      data_rd = (k == rd_at);
      if (k == rst_at) rst = 1'b1;
      if (k == rst_at + 2) rst = 1'b0;
      if (flip_cfg && k == 100) parity_en = ~parity_en;
      if (k == rst_at + 1) begin
        snap_dout = data_out;
        snap_dv   = data_valid;
        snap_perr = parity_err;
        snap_ferr = frame_err;
        snap_ovr  = overrun;
        snap_busy = busy;
      end
      if (data_valid && !prev_dv && rise_k < 0) rise_k = k;
      prev_dv = data_valid;
    end
    data_rd = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    idle(3);
    check("rst_dout", data_out, 8'h00);
    check("rst_dv", data_valid, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", state_dbg, ST_IDLE);
    rst = 1'b0;
    idle(8);

    // Plain 8N1 frame, exact commit latency
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
    idle(8);
    check("a5_latency", rise_k, 609);
    check("a5_dout", data_out, 8'hA5);
    check("a5_dv", data_valid, 1'b1);
    check("a5_perr", parity_err, 1'b0);
    check("a5_ferr", frame_err, 1'b0);
    check("a5_ovr", overrun, 1'b0);
    check("a5_busy", busy, 1'b0);
    pulse_rd();
    check("a5_rd_dv", data_valid, 1'b0);

    // Even parity: 0x3C has four ones, so parity bit 0 is correct
    parity_en = 1'b1;
    parity_odd = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1, -1, 1'b0);
    idle(8);
    check("par_ok_latency", rise_k, 673);
    check("par_ok_dout", data_out, 8'h3C);
    check("par_ok_perr", parity_err, 1'b0);
    pulse_rd();
    // Wrong parity bit; config toggled mid-frame must be ignored
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1, -1, 1'b1);
    idle(8);
    check("par_bad_dout", data_out, 8'h3C);
    check("par_bad_perr", parity_err, 1'b1);
    check("par_bad_ferr", frame_err, 1'b0);
    check("par_bad_dv", data_valid, 1'b1);
    pulse_rd();
    parity_en = 1'b0;

    // False start: 4 ticks low then high
    rx_in = 1'b0;
    idle(16);
    check("fs_busy_hi", busy, 1'b1);
    rx_in = 1'b1;
    idle(40);
    check("fs_busy_lo", busy, 1'b0);
    check("fs_dv", data_valid, 1'b0);
    check("fs_state", state_dbg, ST_IDLE);

    // Break: 0x00 with low stop, line held low
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0);
    idle(80);
    check("brk_dv", data_valid, 1'b1);
    check("brk_ferr", frame_err, 1'b1);
    check("brk_dout", data_out, 8'h00);
    check("brk_state", state_dbg, ST_BREAK);
    pulse_rd();
    idle(78);
    check("brk_once_dv", data_valid, 1'b0);
    check("brk_hold_state", state_dbg, ST_BREAK);
    rx_in = 1'b1;
    idle(6);
    check("brk_exit_state", state_dbg, ST_IDLE);
    check("brk_exit_busy", busy, 1'b0);

    // Overrun and its clearing
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
    idle(8);
    check("ovr_first_ovr", overrun, 1'b0);
    check("ovr_first_ferr", frame_err, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
    idle(8);
    check("ovr_dout", data_out, 8'h22);
    check("ovr_set", overrun, 1'b1);
    check("ovr_dv", data_valid, 1'b1);
    pulse_rd();
    check("ovr_rd_dv", data_valid, 1'b0);
    check("ovr_rd_ovr", overrun, 1'b0);
    pulse_rd();
    check("rd_idle_dv", data_valid, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
    idle(8);
    // data_rd lands in the stop-sample cycle of the next frame
    send_frame(8'h44, 1'b0, 1'b0, 1'b1, 608, -1, 1'b0);
    idle(8);
    check("coin_dout", data_out, 8'h44);
    check("coin_dv", data_valid, 1'b1);
    check("coin_ovr", overrun, 1'b0);

    // Reset during bit 3 of 0xFF
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, -1, 280, 1'b0);
    idle(8);
    check("mrst_dout", snap_dout, 8'h00);
    check("mrst_dv", snap_dv, 1'b0);
    check("mrst_perr", snap_perr, 1'b0);
    check("mrst_ferr", snap_ferr, 1'b0);
    check("mrst_ovr", snap_ovr, 1'b0);
    check("mrst_busy", snap_busy, 1'b0);
    check("mrst_nocommit", rise_k, -1);
    check("mrst_after_dv", data_valid, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
    idle(8);
    check("post_latency", rise_k, 609);
    check("post_dout", data_out, 8'h5A);
    check("post_ferr", frame_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
